// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the registered decode/control unit.
//   - RISC-V opcode constants, including the custom STC offload opcode
//   - ALUOp encodings
//   - ctrl_bundle_t: the control bundle handed to the execute stage
//   - DEFAULT_BUNDLE: bundle used for STC, unknown opcodes and reset
//   - state_t: control FSM states
package ctrl_pkg;

  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_STC    = 7'b0001011;
  localparam logic [6:0] OPC_VECTOR = 7'b1010111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       imm_select;
    logic       is_branch;
    logic       is_vector;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t DEFAULT_BUNDLE = '{
    alu_op:     ALUOP_IMM,
    alu_src:    1'b1,
    reg_write:  1'b0,
    mem_rd:     1'b0,
    mem_wr:     1'b0,
    mem_to_reg: 1'b0,
    imm_select: 1'b0,
    is_branch:  1'b0,
    is_vector:  1'b0,
    illegal:    1'b0
  };

  typedef enum logic {
    ST_IDLE,
    ST_CGRA_WAIT
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder
// Purely combinational mapping from a 7-bit opcode to the control bundle.
// STC decodes to the default bundle (the FSM handles its sequencing);
// anything not recognised gets the default bundle with illegal set.
// Build option: VECTOR_EN enables decoding of the vector opcode; without
// it that opcode is illegal and is_vector is never set.
// Ports:
//   opcode  in   7  instruction opcode field
//   bundle  out  ctrl_bundle_t decoded control bundle
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output ctrl_bundle_t bundle
);

  always_comb begin
    bundle = DEFAULT_BUNDLE;
    case (opcode)
      OPC_ADDI: begin
        bundle           = '0;
        bundle.alu_op    = ALUOP_IMM;
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
      end
      OPC_RTYPE: begin
        bundle           = '0;
        bundle.alu_op    = ALUOP_RTYPE;
        bundle.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        bundle           = '0;
        bundle.alu_op    = ALUOP_BRANCH;
        bundle.alu_src   = 1'b1;
        bundle.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        bundle            = '0;
        bundle.alu_op     = ALUOP_MEM;
        bundle.alu_src    = 1'b1;
        bundle.mem_rd     = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
      end
      OPC_STORE: begin
        bundle            = '0;
        bundle.alu_op     = ALUOP_MEM;
        bundle.alu_src    = 1'b1;
        bundle.mem_wr     = 1'b1;
        bundle.imm_select = 1'b1;
      end
      OPC_STC: begin
        bundle = DEFAULT_BUNDLE;
      end
`ifdef VECTOR_EN
      OPC_VECTOR: begin
        bundle           = '0;
        bundle.alu_op    = ALUOP_MEM;
        bundle.reg_write = 1'b1;
        bundle.is_vector = 1'b1;
      end
`endif
      default: begin
        bundle         = DEFAULT_BUNDLE;
        bundle.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_unit.sv
// decode_ctrl_unit
// Registered, handshaked main decoder. Decodes the opcode into the control
// bundle and runs the STC instruction as a blocking CGRA offload with a
// start pulse, completion wait and timeout abort. Fetch is stalled
// (instr_ready_o low) for the whole offload.
// Build option: VECTOR_EN (see opcode_decoder) enables the vector opcode.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   instr_i, instr_valid_i/ready_o  upstream instruction handshake
//   flush_i                         drop current/pending result
//   ctrl_valid_o, ctrl_ready_i      downstream bundle handshake
//   ALUOp_o .. illegal_o            registered control bundle
//   cgra_start_o, cgra_cfg_o        offload start pulse and config word
//   cgra_done_i, cgra_timeout_o     completion input and abort pulse
module decode_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int CGRA_TIMEOUT = 255,
  parameter int ALUOP_W      = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [31:0]        instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic               flush_i,
  output logic               ctrl_valid_o,
  input  logic               ctrl_ready_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic               MemRd_o,
  output logic               MemWr_o,
  output logic               MemToReg_o,
  output logic               immSelect_o,
  output logic               isBranch_o,
  output logic               isVector_o,
  output logic               illegal_o,
  output logic               cgra_start_o,
  output logic [24:0]        cgra_cfg_o,
  input  logic               cgra_done_i,
  output logic               cgra_timeout_o
);

  localparam int CNT_W = $clog2(CGRA_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CGRA_TIMEOUT);

  state_t       state_q, state_d;
  logic         valid_q, valid_d;
  ctrl_bundle_t bundle_q, bundle_d;
  logic         start_q, start_d;
  logic         timeout_q, timeout_d;
  logic [24:0]  cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         drop_q, drop_d;
  logic         ready;
  ctrl_bundle_t dec_bundle;

  opcode_decoder u_opcode_decoder (
    .opcode (instr_i[6:0]),
    .bundle (dec_bundle)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      bundle_q  <= DEFAULT_BUNDLE;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      cfg_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      bundle_q  <= bundle_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    bundle_d  = bundle_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = !valid_q || ctrl_ready_i;
        if (valid_q && ctrl_ready_i) valid_d = 1'b0;
        // A flush kills both the presented bundle and any same-cycle accept.
        if (flush_i) begin
          valid_d = 1'b0;
        end else if (instr_valid_i && ready) begin
          if (instr_i[6:0] == OPC_STC) begin
            state_d = ST_CGRA_WAIT;
            start_d = 1'b1;
            cfg_d   = instr_i[31:7];
            cnt_d   = '0;
            drop_d  = 1'b0;
          end else begin
            bundle_d = dec_bundle;
            valid_d  = 1'b1;
          end
        end
      end
      ST_CGRA_WAIT: begin
        // Saturating count; the state is left at CNT_MAX so it never wraps.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) drop_d = 1'b1;
        // Done takes priority over a coincident timeout. A flushed offload
        // still runs to completion but produces no bundle.
        if (cgra_done_i || (cnt_q == CNT_MAX)) begin
          state_d   = ST_IDLE;
          drop_d    = 1'b0;
          timeout_d = !cgra_done_i;
          if (!(drop_q || flush_i)) begin
            valid_d          = 1'b1;
            bundle_d         = DEFAULT_BUNDLE;
            bundle_d.illegal = !cgra_done_i;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr_ready_o  = ready;
  assign ctrl_valid_o   = valid_q;
  assign ALUOp_o        = ALUOP_W'(bundle_q.alu_op);
  assign ALUSrc_o       = bundle_q.alu_src;
  assign RegWrite_o     = bundle_q.reg_write;
  assign MemRd_o        = bundle_q.mem_rd;
  assign MemWr_o        = bundle_q.mem_wr;
  assign MemToReg_o     = bundle_q.mem_to_reg;
  assign immSelect_o    = bundle_q.imm_select;
  assign isBranch_o     = bundle_q.is_branch;
  assign isVector_o     = bundle_q.is_vector;
  assign illegal_o      = bundle_q.illegal;
  assign cgra_start_o   = start_q;
  assign cgra_cfg_o     = cfg_q;
  assign cgra_timeout_o = timeout_q;

endmodule
